// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB master bridge and the timer it talks to:
// FSM state encoding and the timer register map constants.
package apb_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } apb_state_e;

  // Timer control register address and its enable bit position
  localparam logic [7:0]  ADDR_TCR   = 8'h01;
  localparam int unsigned TCR_EN_BIT = 4;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the APB ACCESS phase. It counts ACCESS cycles in
// which the slave is not ready and flags expiry during the TIMEOUT-th one.
// TIMEOUT = 0 disables expiry entirely.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Saturation point and the count value seen during the last allowed cycle
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is only meaningful while a waiting ACCESS cycle is in progress
  assign expired = (TIMEOUT != 0) && enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: turns a valid/ready command into a
// SETUP/ACCESS APB transfer, absorbs wait states, aborts hung transfers
// after TIMEOUT ACCESS cycles and returns a one-cycle response strobe.
module apb_master_bridge
  import apb_timer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_e            state_q,     state_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic                  pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;

  logic to_clear;
  logic to_enable;
  logic to_expired;

  // Counter restarts on command acceptance and runs on waiting ACCESS cycles
  assign to_clear  = (state_q == IDLE) && cmd_valid;
  assign to_enable = (state_q == ACCESS) && !pready;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .pclk     (pclk),
    .preset_n (preset_n),
    .clear    (to_clear),
    .enable   (to_enable),
    .expired  (to_expired)
  );

  // Next-state and next-output logic; bus outputs derive from the next state
  // so that psel/penable/rsp_valid are registered and line up with the state
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = {DATA_WIDTH{1'b0}};
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          // pslverr is only looked at when the slave completes
          state_d     = RESP;
          rsp_rdata_d = pwrite_q ? {DATA_WIDTH{1'b0}} : prdata;
          rsp_err_d   = pslverr;
        end else if (to_expired) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers; reset drops any in-flight transfer
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= {ADDR_WIDTH{1'b0}};
      pwdata_q    <= {DATA_WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: an APB slave model with programmable wait
// states, error and hang behaviour, plus a reference memory that predicts
// every response and its latency.
module tb_apb_master_bridge;
  import apb_timer_pkg::*;

  localparam int TO = 16;

  logic       pclk;
  logic       preset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  int n_assert = 0;
  int n_fail   = 0;

  // Slave model state
  logic [7:0] slv_mem [256];
  logic [7:0] ref_mem [256];
  int         slv_waits = 0;
  logic       slv_err   = 1'b0;
  logic       slv_hang  = 1'b0;
  logic       slv_init  = 1'b1;
  int         acc_cnt   = 0;

  apb_master_bridge #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .TIMEOUT    (TO)
  ) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Slave: ready after slv_waits waiting ACCESS cycles; pslverr is noisy (1)
  // while not ready so that the bridge must ignore it then
  assign pready  = psel && penable && !slv_hang && (acc_cnt >= slv_waits);
  assign prdata  = slv_mem[paddr];
  assign pslverr = pready ? slv_err : 1'b1;

  // Slave wait counter and register writes
  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (slv_init) begin
      for (int i = 0; i < 256; i++) slv_mem[i] <= 8'(i * 7 + 3);
    end else if (psel && penable && pready && pwrite && !slv_err) begin
      slv_mem[paddr] <= pwdata;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One complete command with timing checks. With chain set, cmd_valid stays
  // high after acceptance carrying the next command.
  task automatic do_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                        input int waits, input logic err, input logic hang,
                        input logic chain, input logic nwr, input logic [7:0] naddr,
                        input logic [7:0] nwd);
    logic       exp_err;
    logic [7:0] exp_rd;
    int         exp_cycles;
    int         pen_cnt;
    @(negedge pclk);
    slv_waits = waits;
    slv_err   = err;
    slv_hang  = hang;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    chk1("idle_cmd_ready", cmd_ready, 1'b1);
    if (hang) begin
      exp_err    = 1'b1;
      exp_rd     = 8'h00;
      exp_cycles = TO;
    end else begin
      exp_err    = err;
      exp_rd     = wr ? 8'h00 : ref_mem[addr];
      exp_cycles = waits + 1;
      if (wr && !err) ref_mem[addr] = wd;
    end
    @(posedge pclk); #1;
    if (chain) begin
      cmd_write = nwr;
      cmd_addr  = naddr;
      cmd_wdata = nwd;
    end else begin
      cmd_valid = 1'b0;
    end
    chk1("setup_psel", psel, 1'b1);
    chk1("setup_penable", penable, 1'b0);
    chk8("setup_paddr", paddr, addr);
    chk1("setup_pwrite", pwrite, wr);
    if (wr) chk8("setup_pwdata", pwdata, wd);
    chk1("setup_cmd_ready", cmd_ready, 1'b0);
    @(posedge pclk); #1;
    chk1("access_psel", psel, 1'b1);
    chk1("access_penable", penable, 1'b1);
    pen_cnt = 0;
    for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) begin
      if (penable === 1'b1) pen_cnt++;
      chk8("access_paddr_stable", paddr, addr);
      chk1("access_cmd_ready", cmd_ready, 1'b0);
      @(posedge pclk); #1;
    end
    chk1("rsp_valid_seen", rsp_valid, 1'b1);
    chk32("access_cycles", pen_cnt, exp_cycles);
    chk1("rsp_psel", psel, 1'b0);
    chk1("rsp_penable", penable, 1'b0);
    chk1("rsp_err", rsp_err, exp_err);
    chk8("rsp_rdata", rsp_rdata, exp_rd);
    chk1("rsp_cmd_ready", cmd_ready, 1'b0);
    @(posedge pclk); #1;
    chk1("post_rsp_valid", rsp_valid, 1'b0);
    chk1("post_cmd_ready", cmd_ready, 1'b1);
    chk1("post_psel", psel, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_psel"}, psel, 1'b0);
    chk1({tag, "_penable"}, penable, 1'b0);
    chk1({tag, "_pwrite"}, pwrite, 1'b0);
    chk8({tag, "_paddr"}, paddr, 8'h00);
    chk8({tag, "_pwdata"}, pwdata, 8'h00);
    chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk8({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
    chk1({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk1({tag, "_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       r_wr;
    logic       r_err;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    int         r_waits;

    preset_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
    repeat (3) @(posedge pclk);
    #1;
    chk_all_zero("reset");
    @(negedge pclk);
    slv_init = 1'b0;
    preset_n = 1'b1;

    // TCR enable write, zero waits, then read it back
    do_txn(1'b1, ADDR_TCR, 8'h10, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk1("tcr_en_bit", slv_mem[ADDR_TCR][TCR_EN_BIT], 1'b1);
    do_txn(1'b0, ADDR_TCR, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Read 0xA5 with three wait states
    do_txn(1'b1, 8'h01, 8'hA5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    do_txn(1'b0, 8'h01, 8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Hung slave: abort after TIMEOUT ACCESS cycles
    do_txn(1'b0, 8'h02, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Slave error on a read still returns the data
    do_txn(1'b1, 8'h20, 8'h3C, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    do_txn(1'b0, 8'h20, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset pulse during ACCESS drops the transfer without a response
    @(negedge pclk);
    slv_waits = 5;
    slv_err   = 1'b0;
    slv_hang  = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h40;
    cmd_wdata = 8'h77;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    @(posedge pclk); #1;
    chk1("pre_reset_penable", penable, 1'b1);
    @(posedge pclk); #3;
    preset_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge pclk);
    preset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge pclk); #1;
      chk1("no_rsp_after_reset", rsp_valid, 1'b0);
      chk1("no_psel_after_reset", psel, 1'b0);
    end
    do_txn(1'b0, 8'h40, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Back-to-back commands with cmd_valid held high
    do_txn(1'b1, 8'h30, 8'h99, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 8'h00);
    do_txn(1'b0, 8'h30, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Random traffic against the reference memory
    for (int k = 0; k < 24; k++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_addr  = 8'($urandom_range(0, 15));
      r_data  = 8'($urandom_range(0, 255));
      r_waits = int'($urandom_range(0, 3));
      r_err   = ($urandom_range(0, 5) == 0);
      do_txn(r_wr, r_addr, r_data, r_waits, r_err, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
